// File: rtl/button_pulse_conditioner.sv
// Per-channel button conditioner: 2-FF synchronizer, debounce counter and registered rising-edge
// toggle pulse. Define BTN_LONG_PRESS_EN to add per-channel hold counters driving long_pulse.
module button_pulse_conditioner #(
  parameter int unsigned N_BTN             = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned LONG_PRESS_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic             busy
);

  if (N_BTN < 1) begin : g_chk_n_btn
    $error("N_BTN must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES < 2) begin : g_chk_long
    $error("LONG_PRESS_CYCLES must be >= 2");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [CntW-1:0]  cnt_q [N_BTN];
  logic [CntW-1:0]  cnt_d [N_BTN];

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    busy    = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
      // Pulse only on an accepted 0->1; a disabled press is dropped, not deferred.
      pulse_d[i] = level_d[i] & ~level_q[i] & enable;
      busy       = busy | (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] HoldArm = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

  logic [HoldW-1:0] hold_q [N_BTN];
  logic [HoldW-1:0] hold_d [N_BTN];
  logic [N_BTN-1:0] long_q, long_d;

  always_comb begin
    long_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      hold_d[i] = '0;
      if (level_q[i]) begin
        hold_d[i] = (hold_q[i] == HoldMax) ? hold_q[i] : hold_q[i] + HoldOne;
      end
      // Fires on the edge the counter reaches its saturation value, hence once per press.
      long_d[i] = level_q[i] & (hold_q[i] == HoldArm) & enable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      long_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Self-checking bench for button_pulse_conditioner: directed scenarios plus randomized traffic,
// all checked against a sample-history reference model. Honours BTN_LONG_PRESS_EN.
module tb_button_pulse_conditioner;
  localparam int N = 4;
  localparam int D = 16;
  localparam int L = 8;
  localparam int W = 3 * N + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_pulse, long_pulse;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  button_pulse_conditioner #(
    .N_BTN             (N),
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .enable     (enable),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .long_pulse (long_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: keep the last D synchronized samples per channel; a level change is
  // accepted when all D of them disagree with the current level.
  bit           m_s1 [N];
  bit           m_s2 [N];
  bit           hist [N][$];
  int           rise_edge [N];
  int           edge_cnt = 0;
  logic [N-1:0] m_level = '0, m_pulse = '0, m_long = '0;
  logic         m_busy = 1'b0;

  wire [W-1:0] obs  = {btn_level, btn_pulse, long_pulse, busy};
  wire [W-1:0] expv = {m_level, m_pulse, m_long, m_busy};

  task automatic step();
    logic old;
    bit   acc;
    bit   stop;
    int   run;
    @(posedge clk);
    edge_cnt++;
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_s1[c] = 0;
        m_s2[c] = 0;
        hist[c].delete();
      end
      m_level = '0;
      m_pulse = '0;
      m_long  = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        old        = m_level[c];
        m_pulse[c] = 1'b0;
        m_long[c]  = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        if (old && (edge_cnt - rise_edge[c] == L) && enable) m_long[c] = 1'b1;
`endif
        hist[c].push_back(m_s2[c]);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        acc = (hist[c].size() == D);
        for (int j = 0; j < hist[c].size(); j++) if (hist[c][j] == old) acc = 0;
        if (acc) begin
          m_level[c] = ~old;
          if (!old) begin
            rise_edge[c] = edge_cnt;
            m_pulse[c]   = enable;
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = btn_raw[c];
      end
    end
    m_busy = 1'b0;
    for (int c = 0; c < N; c++) begin
      run  = 0;
      stop = 0;
      for (int j = hist[c].size() - 1; j >= 0; j--) begin
        if (hist[c][j] == m_level[c]) stop = 1;
        else if (!stop) run++;
      end
      if (run > 0) m_busy = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    btn_raw = N'($urandom);
    step();
    step();
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_zero got=%h exp=0", obs);
    end
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_model got=%h exp=%h", obs, expv);
    end
    n_tests++;
    reset   = 1'b0;
    btn_raw = '0;
  endtask

  task automatic test_release(input int n);
    btn_raw = '0;
    repeat (n) begin
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL release_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int cnt   = 0;
    logic busy_mid = 1'b0;
    btn_raw[0] = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL clean_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_pulse[0]) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 5) busy_mid = busy;
    end
    if (first != 17 || cnt != 1) begin
      n_fail++;
      $display("FAIL clean_pulse_edge got edge=%0d count=%0d exp edge=17 count=1", first, cnt);
    end
    n_tests++;
    if (busy_mid !== 1'b1 || busy !== 1'b0 || btn_level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_busy got mid=%b end=%b level=%b exp 1 0 1", busy_mid, busy,
               btn_level[0]);
    end
    n_tests++;
  endtask

  task automatic test_bounce();
    int first = -1;
    int cnt   = 0;
    for (int c = 0; c <= 100; c++) begin
      btn_raw[1] = (c >= 60) ? 1'b1 : (((c / 3) % 2) == 0);
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL bounce_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_pulse[1]) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    if (first != 77 || cnt != 1) begin
      n_fail++;
      $display("FAIL bounce_pulse got edge=%0d count=%0d exp edge=77 count=1", first, cnt);
    end
    n_tests++;
  endtask

  task automatic test_glitch();
    int cnt = 0;
    for (int c = 0; c < 30; c++) begin
      btn_raw[2] = (c < 10);
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL glitch_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_pulse[2] || btn_level[2]) cnt++;
    end
    if (cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_quiet got activity=%0d busy=%b exp 0 0", cnt, busy);
    end
    n_tests++;
  endtask

  task automatic test_enable();
    int cnt = 0;
    enable     = 1'b0;
    btn_raw[3] = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (c == 25) enable = 1'b1;
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL enable_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_pulse[3]) cnt++;
    end
    if (cnt != 0 || btn_level[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_gate got pulses=%0d level=%b exp 0 1", cnt, btn_level[3]);
    end
    n_tests++;
  endtask

  task automatic test_simul_reset();
    int e0 = -1;
    int e1 = -1;
    int e2 = -1;
    btn_raw[1:0] = 2'b11;
    for (int k = 0; k < 25; k++) begin
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL simul_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_pulse[0] && e0 < 0) e0 = k;
      if (btn_pulse[1] && e1 < 0) e1 = k;
    end
    if (e0 != 17 || e1 != 17) begin
      n_fail++;
      $display("FAIL simul_same_edge got e0=%0d e1=%0d exp 17 17", e0, e1);
    end
    n_tests++;
    test_release(25);
    btn_raw[2] = 1'b1;
    repeat (8) step();
    reset = 1'b1;
    step();
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_zero got=%h exp=0", obs);
    end
    n_tests++;
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL post_reset_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_pulse[2] && e2 < 0) e2 = k;
    end
    if (e2 != 18) begin
      n_fail++;
      $display("FAIL post_reset_pulse got edge=%0d exp 18", e2);
    end
    n_tests++;
  endtask

  task automatic test_long_press();
    int rise  = -1;
    int first = -1;
    int cnt   = 0;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL long_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
      if (btn_level[0] && rise < 0) rise = k;
      if (long_pulse[0]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
`ifdef BTN_LONG_PRESS_EN
    if (rise != 17 || cnt != 1 || first != 17 + L) begin
      n_fail++;
      $display("FAIL long_pulse got rise=%0d long=%0d count=%0d exp 17 %0d 1", rise, first, cnt,
               17 + L);
    end
`else
    if (rise != 17 || cnt != 0) begin
      n_fail++;
      $display("FAIL long_absent got rise=%0d count=%0d exp 17 0", rise, cnt);
    end
`endif
    n_tests++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(15) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(31) == 0) enable = ~enable;
      reset = ($urandom_range(499) == 0);
      step();
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL random_model edge=%0d got=%h exp=%h", edge_cnt, obs, expv);
      end
      n_tests++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    btn_raw = '0;
    for (int c = 0; c < N; c++) rise_edge[c] = 0;
    test_reset();
    test_clean_press();
    test_release(25);
    test_bounce();
    test_release(25);
    test_glitch();
    test_enable();
    test_release(25);
    test_simul_reset();
    test_release(25);
    test_long_press();
    test_release(25);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
